// File: rtl/inorder_retire_ctrl.sv
// In-order retirement window: sequential ID allocation, out-of-order completion
// tracking, and capped in-order retirement of the completed run at the head.

module count_one #(
  parameter int W          = 8,
  parameter bit CONTINUOUS = 1'b1,
  parameter int CW         = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  logic run_s;

  // CONTINUOUS counts only the unbroken run of ones starting at bit 0
  always_comb begin
    cnt_o = '0;
    run_s = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (CONTINUOUS) begin
        run_s = run_s & vec_i[i];
      end else begin
        run_s = vec_i[i];
      end
      if (run_s) begin
        cnt_o = cnt_o + CW'(1);
      end else begin
        cnt_o = cnt_o;
      end
    end
  end

endmodule

module inorder_retire_ctrl #(
  parameter int DEPTH        = 8,
  parameter int ALLOC_WIDTH  = 2,
  parameter int DONE_PORTS   = 2,
  parameter int RETIRE_WIDTH = 3,
  parameter int ID_WIDTH     = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            alloc_valid,
  input  logic [$clog2(ALLOC_WIDTH):0]    alloc_num,
  output logic                            alloc_ready,
  output logic [ALLOC_WIDTH*ID_WIDTH-1:0] alloc_id,
  input  logic [DONE_PORTS-1:0]           done_valid,
  input  logic [DONE_PORTS*ID_WIDTH-1:0]  done_id,
  input  logic                            retire_stall,
  output logic                            retire_valid,
  output logic [$clog2(RETIRE_WIDTH):0]   retire_num,
  output logic [ID_WIDTH-1:0]             retire_head_id,
  output logic [ID_WIDTH:0]               occupancy,
  output logic                            empty,
  output logic                            full
);

  localparam int AN_W  = $clog2(ALLOC_WIDTH) + 1;
  localparam int RN_W  = $clog2(RETIRE_WIDTH) + 1;
  localparam int OC_W  = ID_WIDTH + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    done_q, done_d;
  logic [ID_WIDTH-1:0] head_q, head_d;
  logic [ID_WIDTH-1:0] tail_q, tail_d;
  logic [OC_W-1:0]     occ_q, occ_d;

  logic [DEPTH-1:0]    ready_rot_s;
  logic [CNT_W-1:0]    run_len_s;
  logic [OC_W-1:0]     free_s;
  logic                alloc_fire_s;
  logic [ID_WIDTH-1:0] rot_idx_s;

  // Rotate the retirable mask so bit 0 is the head entry; wraps modulo DEPTH
  always_comb begin
    ready_rot_s = '0;
    rot_idx_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rot_idx_s      = head_q + ID_WIDTH'(i);
      ready_rot_s[i] = valid_q[rot_idx_s] & done_q[rot_idx_s];
    end
  end

  count_one #(
    .W          (DEPTH),
    .CONTINUOUS (1'b1),
    .CW         (CNT_W)
  ) u_run_len (
    .vec_i (ready_rot_s),
    .cnt_o (run_len_s)
  );

  // Retire count: capped run length, suppressed by stall or flush
  always_comb begin
    if (flush || retire_stall) begin
      retire_num = '0;
    end else if (run_len_s > CNT_W'(RETIRE_WIDTH)) begin
      retire_num = RN_W'(RETIRE_WIDTH);
    end else begin
      retire_num = RN_W'(run_len_s);
    end
  end

  // Admission uses pre-retire occupancy, so slots freed this cycle wait a cycle
  assign free_s         = OC_W'(DEPTH) - occ_q;
  assign alloc_ready    = !flush && (free_s >= OC_W'(alloc_num));
  assign alloc_fire_s   = alloc_valid && alloc_ready;
  assign retire_valid   = (retire_num != '0);
  assign retire_head_id = head_q;
  assign occupancy      = occ_q;
  assign empty          = (occ_q == '0);
  assign full           = (occ_q == OC_W'(DEPTH));

  for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_alloc_id
    assign alloc_id[g*ID_WIDTH +: ID_WIDTH] = tail_q + ID_WIDTH'(g);
  end

  // Next state: completion, then retire-clear, then allocation (disjoint slots)
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    idx     = '0;
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      occ_d   = '0;
    end else begin
      for (int p = 0; p < DONE_PORTS; p++) begin
        idx = done_id[p*ID_WIDTH +: ID_WIDTH];
        if (done_valid[p] && valid_q[idx]) begin
          done_d[idx] = 1'b1;
        end else begin
          done_d[idx] = done_d[idx];
        end
      end
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        idx = head_q + ID_WIDTH'(i);
        if (RN_W'(i) < retire_num) begin
          valid_d[idx] = 1'b0;
          done_d[idx]  = 1'b0;
        end else begin
          valid_d[idx] = valid_d[idx];
        end
      end
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
        idx = tail_q + ID_WIDTH'(i);
        if (alloc_fire_s && (AN_W'(i) < alloc_num)) begin
          valid_d[idx] = 1'b1;
          done_d[idx]  = 1'b0;
        end else begin
          valid_d[idx] = valid_d[idx];
        end
      end
      head_d = head_q + ID_WIDTH'(retire_num);
      if (alloc_fire_s) begin
        tail_d = tail_q + ID_WIDTH'(alloc_num);
        occ_d  = occ_q + OC_W'(alloc_num) - OC_W'(retire_num);
      end else begin
        tail_d = tail_q;
        occ_d  = occ_q - OC_W'(retire_num);
      end
    end
  end

  // Window state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

endmodule
